eth_serdes_rx_slip: RTL and testbench

ETH_SERDES_RX_SLIP -- requirements
Module: eth_serdes_rx_slip

---
 rtl/eth_serdes_rx_slip_if.sv | 27 ++
 rtl/eth_serdes_rx_slip.sv | 100 ++++++++++
 tb/tb_eth_serdes_rx_slip.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/eth_serdes_rx_slip_if.sv
// Stream bundle for the 66b bit-slip aligner: raw line words and slip request in,
// aligned payload/header and the current bit offset out.
interface eth_serdes_rx_slip_if #(
    parameter int DATA_WIDTH = 64,
    parameter int HDR_WIDTH  = 2
);
    localparam int BLK_W = DATA_WIDTH + HDR_WIDTH;
    localparam int OFF_W = $clog2(BLK_W);

    logic [BLK_W-1:0]      in_word;
    logic                  in_valid;
    logic                  serdes_rx_bitslip;
    logic [DATA_WIDTH-1:0] serdes_rx_data;
    logic [HDR_WIDTH-1:0]  serdes_rx_hdr;
    logic                  serdes_rx_valid;
    logic [OFF_W-1:0]      slip_offset;

    modport master (
        output in_word, in_valid, serdes_rx_bitslip,
        input  serdes_rx_data, serdes_rx_hdr, serdes_rx_valid, slip_offset
    );

    modport slave (
        input  in_word, in_valid, serdes_rx_bitslip,
        output serdes_rx_data, serdes_rx_hdr, serdes_rx_valid, slip_offset
    );
endinterface

// File: rtl/eth_serdes_rx_slip.sv
// Bit-slip aligner: picks a 66b window out of the current and previous line word at a
// slip-controlled bit offset; slips are rising-edge triggered with a holdoff window.
module eth_serdes_rx_slip #(
    parameter int DATA_WIDTH   = 64,
    parameter int HDR_WIDTH    = 2,
    parameter int SLIP_HOLDOFF = 4
) (
    input  logic rx_clk,
    input  logic rx_rst,
    eth_serdes_rx_slip_if.slave bus
);
    localparam int BLK_W = DATA_WIDTH + HDR_WIDTH;
    localparam int OFF_W = $clog2(BLK_W);
    localparam int IDX_W = $clog2(2 * BLK_W);
    localparam int HO_W  = (SLIP_HOLDOFF > 0) ? $clog2(SLIP_HOLDOFF + 1) : 1;

    logic [BLK_W-1:0]      prev_word_reg, prev_word_next;
    logic                  primed_reg, primed_next;
    logic [OFF_W-1:0]      offset_reg, offset_next;
    logic [HO_W-1:0]       holdoff_reg, holdoff_next;
    logic                  bitslip_reg, bitslip_next;
    logic                  armed_reg, armed_next;
    logic [DATA_WIDTH-1:0] data_reg, data_next;
    logic [HDR_WIDTH-1:0]  hdr_reg, hdr_next;
    logic                  valid_reg, valid_next;

    logic [2*BLK_W-1:0]    concat;
    logic [IDX_W-1:0]      sel_idx;
    logic [BLK_W-1:0]      window;
    logic                  slip_rise;
    logic                  slip_accept;

    // Offset 0 selects prev_word whole; higher offsets pull low bits of in_word in on top.
    assign concat  = {bus.in_word, prev_word_reg};
    assign sel_idx = IDX_W'(offset_reg);
    assign window  = concat[sel_idx +: BLK_W];

    // armed_reg blocks a request that is already high when reset releases from
    // being seen as an edge; it sets once the request has been observed low.
    assign slip_rise   = bus.serdes_rx_bitslip & ~bitslip_reg & armed_reg;
    assign slip_accept = slip_rise & (holdoff_reg == '0);

    always_comb begin
        prev_word_next = prev_word_reg;
        primed_next    = primed_reg;
        offset_next    = offset_reg;
        holdoff_next   = holdoff_reg;
        bitslip_next   = bus.serdes_rx_bitslip;
        armed_next     = armed_reg | ~bus.serdes_rx_bitslip;
        data_next      = data_reg;
        hdr_next       = hdr_reg;
        valid_next     = 1'b0;

        if (slip_accept) begin
            offset_next  = (offset_reg == OFF_W'(BLK_W - 1)) ? '0 : offset_reg + OFF_W'(1);
            holdoff_next = HO_W'(SLIP_HOLDOFF);
        end else if (holdoff_reg != '0) begin
            holdoff_next = holdoff_reg - HO_W'(1);
        end

        if (bus.in_valid) begin
            prev_word_next = bus.in_word;
            primed_next    = 1'b1;
            if (primed_reg) begin
                data_next  = window[BLK_W-1:HDR_WIDTH];
                hdr_next   = window[HDR_WIDTH-1:0];
                valid_next = 1'b1;
            end
        end
    end

    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            prev_word_reg <= '0;
            primed_reg    <= 1'b0;
            offset_reg    <= '0;
            holdoff_reg   <= '0;
            bitslip_reg   <= 1'b0;
            armed_reg     <= 1'b0;
            data_reg      <= '0;
            hdr_reg       <= '0;
            valid_reg     <= 1'b0;
        end else begin
            prev_word_reg <= prev_word_next;
            primed_reg    <= primed_next;
            offset_reg    <= offset_next;
            holdoff_reg   <= holdoff_next;
            bitslip_reg   <= bitslip_next;
            armed_reg     <= armed_next;
            data_reg      <= data_next;
            hdr_reg       <= hdr_next;
            valid_reg     <= valid_next;
        end
    end

    assign bus.serdes_rx_data  = data_reg;
    assign bus.serdes_rx_hdr   = hdr_reg;
    assign bus.serdes_rx_valid = valid_reg;
    assign bus.slip_offset     = offset_reg;
endmodule

// File: tb/tb_eth_serdes_rx_slip.sv
// Directed bench for eth_serdes_rx_slip: expected beats are derived from the absolute
// received bit stream, queued at stimulus time and compared by an independent monitor.
module tb_eth_serdes_rx_slip;
    localparam int DW = 64;
    localparam int HW = 2;
    localparam int BW = 66;

    logic rx_clk = 1'b0;
    logic rx_rst = 1'b1;
    always #5 rx_clk = ~rx_clk;

    eth_serdes_rx_slip_if #(.DATA_WIDTH(DW), .HDR_WIDTH(HW)) bus();

    eth_serdes_rx_slip #(.DATA_WIDTH(DW), .HDR_WIDTH(HW), .SLIP_HOLDOFF(4)) dut (
        .rx_clk (rx_clk),
        .rx_rst (rx_rst),
        .bus    (bus.slave)
    );

    int checks   = 0;
    int failures = 0;
    int beat_no  = 0;
    int exp_off  = 0;
    bit mon_en   = 1'b0;
    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] hist[$];

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Beat k (k>=1 since priming) at offset o carries stream bits 66*(k-1)+o .. +65.
    function automatic logic [BW-1:0] exp_window(input int k, input int o);
        logic [BW-1:0] r;
        logic [BW-1:0] wd;
        int p;
        r = '0;
        for (int b = 0; b < BW; b++) begin
            p    = BW * (k - 1) + o + b;
            wd   = hist[p / BW];
            r[b] = wd[p % BW];
        end
        return r;
    endfunction

    task automatic step(input logic v, input logic [BW-1:0] w, input logic bs, input logic acc);
        @(negedge rx_clk);
        bus.in_valid          = v;
        bus.in_word           = w;
        bus.serdes_rx_bitslip = bs;
        if (v) begin
            hist.push_back(w);
            if (hist.size() > 1)
                exp_q.push_back(exp_window(hist.size() - 1, exp_off));
        end
        if (acc) exp_off = (exp_off + 1) % BW;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input logic bs, input int n);
        @(negedge rx_clk);
        rx_rst                = 1'b1;
        bus.in_valid          = 1'b0;
        bus.in_word           = '0;
        bus.serdes_rx_bitslip = bs;
        hist.delete();
        exp_off = 0;
        repeat (n) @(negedge rx_clk);
        rx_rst = 1'b0;
    endtask

    always @(negedge rx_clk) begin
        if (mon_en && bus.serdes_rx_valid === 1'b1) begin
            beat_no++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat actual=%h required=none",
                         {bus.serdes_rx_data, bus.serdes_rx_hdr});
            end else begin
                logic [BW-1:0] e;
                e = exp_q.pop_front();
                $display("beat %0d data=%h hdr=%b expected=%h", beat_no,
                         bus.serdes_rx_data, bus.serdes_rx_hdr, e);
                check("beat", {bus.serdes_rx_data, bus.serdes_rx_hdr}, e);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [BW-1:0] a, b, c, p, l, w;
        bus.in_valid          = 1'b0;
        bus.in_word           = '0;
        bus.serdes_rx_bitslip = 1'b0;
        do_reset(1'b0, 3);
        mon_en = 1'b1;

        // reset state
        check("rst_valid", BW'(bus.serdes_rx_valid), BW'(0));
        check("rst_offset", BW'(bus.slip_offset), BW'(0));
        check("rst_data", BW'(bus.serdes_rx_data), BW'(0));
        check("rst_hdr", BW'(bus.serdes_rx_hdr), BW'(0));

        // A,B,C at offset 0: outputs A then B
        a = {64'hA5A5_0000_1111_2222, 2'b01};
        b = {64'h3C3C_4444_5555_6666, 2'b01};
        c = {64'h0F0F_7777_8888_9999, 2'b01};
        step(1'b1, a, 1'b0, 1'b0);
        step(1'b1, b, 1'b0, 1'b0);
        step(1'b1, c, 1'b0, 1'b0);
        idle(2);
        check("hold_valid", BW'(bus.serdes_rx_valid), BW'(0));
        check("hold_data", BW'(bus.serdes_rx_data), BW'(b[65:2]));
        check("hold_hdr", BW'(bus.serdes_rx_hdr), BW'(2'b01));

        // pattern shifted by 3 bits, three spaced slips realign it
        p = {64'h0123_4567_89AB_CDEF, 2'b01};
        l = {p[62:0], p[65:63]};
        for (int i = 0; i < 18; i++) step(1'b1, l, (i % 6) == 0, (i % 6) == 0);
        for (int i = 0; i < 4; i++) step(1'b1, l, 1'b0, 1'b0);
        check("align_offset", BW'(bus.slip_offset), BW'(3));
        check("align_hdr", BW'(bus.serdes_rx_hdr), BW'(2'b01));
        check("align_data", BW'(bus.serdes_rx_data), BW'(p[65:2]));

        // level held high counts once
        step(1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 9; i++) step(1'b0, '0, 1'b1, 1'b0);
        idle(2);
        check("level_offset", BW'(bus.slip_offset), BW'(4));

        // second edge inside holdoff dropped
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        idle(6);
        check("holdoff_offset", BW'(bus.slip_offset), BW'(5));

        // walk to 65 with edges exactly at the holdoff boundary
        for (int i = 0; i < 60; i++) begin
            step(1'b0, '0, 1'b1, 1'b1);
            idle(4);
        end
        idle(1);
        check("walk_offset", BW'(bus.slip_offset), BW'(65));

        // wrap 65->0 on a continuous counting stream
        for (int i = 0; i < 12; i++) begin
            w = {32'(i + 1), 34'(~i)};
            step(1'b1, w, i == 6, i == 6);
            if (i >= 1) check("wrap_valid", BW'(bus.serdes_rx_valid), BW'(1));
        end
        idle(2);
        check("wrap_offset", BW'(bus.slip_offset), BW'(0));

        // mid-stream reset at offset 17, request held high across release
        for (int i = 0; i < 17; i++) begin
            step(1'b0, '0, 1'b1, 1'b1);
            idle(4);
        end
        for (int i = 0; i < 3; i++) step(1'b1, {34'(i + 7), 32'hDEAD_0000}, 1'b0, 1'b0);
        check("pre_rst_offset", BW'(bus.slip_offset), BW'(17));
        do_reset(1'b1, 1);
        check("mid_rst_offset", BW'(bus.slip_offset), BW'(0));
        check("mid_rst_valid", BW'(bus.serdes_rx_valid), BW'(0));
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        check("release_offset", BW'(bus.slip_offset), BW'(0));
        a = {64'h1111_2222_3333_4444, 2'b10};
        b = {64'h5555_6666_7777_8888, 2'b01};
        c = {64'h9999_AAAA_BBBB_CCCC, 2'b10};
        step(1'b1, a, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        check("prime_only_valid", BW'(bus.serdes_rx_valid), BW'(0));
        step(1'b1, b, 1'b0, 1'b0);
        step(1'b1, c, 1'b0, 1'b0);
        idle(3);
        check("post_rst_data", BW'(bus.serdes_rx_data), BW'(b[65:2]));
        check("queue_drained", BW'(exp_q.size()), BW'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
